// File: rtl/mandelbrot_worker.sv
// Mandelbrot escape-time worker: accepts one pixel per start_in and iterates
// z <= z^2 + c at two cycles per iteration, then holds the colour with pixel_done high.
module mandelbrot_worker #(
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 720,
    parameter int BITS     = 24,
    parameter int FRAC     = 13,
    parameter int ZOOM     = 8,
    parameter int MAX_ITER = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [$clog2(WIDTH)-1:0]  curr_x,
    input  logic [$clog2(HEIGHT)-1:0] curr_y,
    input  logic [31:0]               timer,
    output logic                      pixel_done,
    output logic [23:0]               color_out,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int SH = FRAC - ZOOM;
    localparam logic signed [BITS:0] ESC_LIM = (BITS+1)'(4 << FRAC);

    typedef enum logic [1:0] {LOAD, MUL, ACC, DONE} state_t;

    state_t r_state, w_next;

    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [7:0]             r_tmr;
    logic [IW-1:0]          r_iter;
    logic signed [BITS-1:0] r_c_re, r_c_im;
    logic signed [BITS-1:0] r_z_re, r_z_im;
    logic signed [BITS-1:0] r_re2, r_im2, r_reim;

    logic signed [BITS-1:0] w_c_re, w_c_im;
    logic signed [BITS:0]   w_mag;
    logic                   w_escape, w_cap, w_finish;
    logic [7:0]             w_k;
    logic [23:0]            w_color;
    logic                   w_unused;

    // Fixed-point multiply: full-width product rescaled by FRAC, truncated to BITS.
    function automatic logic signed [BITS-1:0] fx_mul(input logic signed [BITS-1:0] a,
                                                      input logic signed [BITS-1:0] b);
        logic signed [2*BITS-1:0] p;
        p = a * b;
        return BITS'(p >>> FRAC);
    endfunction

    assign w_unused = ^timer[31:8];

    assign w_c_re = ($signed(BITS'(r_x)) - $signed(BITS'(WIDTH / 2))) <<< SH;
    assign w_c_im = ($signed(BITS'(HEIGHT / 2)) - $signed(BITS'(r_y))) <<< SH;

    assign w_mag    = {r_re2[BITS-1], r_re2} + {r_im2[BITS-1], r_im2};
    assign w_escape = (w_mag > ESC_LIM);
    assign w_cap    = (r_iter == IW'(MAX_ITER));
    assign w_finish = w_escape || w_cap;

    // Escape wins over the cap, so only a non-escaped capped point is black.
    assign w_k     = 8'(r_iter) + r_tmr;
    assign w_color = (w_cap && !w_escape) ? 24'h000000 : {w_k, w_k[6:0], 1'b0, ~w_k};

    assign pixel_done = (r_state == DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= DONE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DONE:    if (start_in) w_next = LOAD;
            LOAD:    w_next = MUL;
            MUL:     w_next = ACC;
            ACC:     w_next = w_finish ? DONE : MUL;
            default: w_next = DONE;
        endcase
    end

    // Iteration datapath; no reset needed since LOAD reinitialises everything.
    always_ff @(posedge clk_in) begin
        case (r_state)
            DONE: begin
                if (start_in) begin
                    r_x   <= curr_x;
                    r_y   <= curr_y;
                    r_tmr <= timer[7:0];
                end
            end
            LOAD: begin
                r_c_re <= w_c_re;
                r_c_im <= w_c_im;
                r_z_re <= '0;
                r_z_im <= '0;
                r_iter <= '0;
            end
            MUL: begin
                r_re2  <= fx_mul(r_z_re, r_z_re);
                r_im2  <= fx_mul(r_z_im, r_z_im);
                r_reim <= fx_mul(r_z_re, r_z_im);
            end
            ACC: begin
                if (!w_finish) begin
                    r_z_re <= r_re2 - r_im2 + r_c_re;
                    r_z_im <= (r_reim <<< 1) + r_c_im;
                    r_iter <= r_iter + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Result registers change only on entry to DONE so the held level stays stable.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            color_out <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (r_state == ACC && w_finish) begin
            color_out <= w_color;
            out_x     <= r_x;
            out_y     <= r_y;
        end
    end

endmodule

// File: tb/tb_mandelbrot_worker.sv
// Directed bench for mandelbrot_worker: reset priming, latency, colour and busy-start handling.
module tb_mandelbrot_worker;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic [31:0] timer;
    logic        pixel_done;
    logic [23:0] color_out;
    logic [10:0] out_x;
    logic [9:0]  out_y;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mandelbrot_worker dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .curr_x     (curr_x),
        .curr_y     (curr_y),
        .timer      (timer),
        .pixel_done (pixel_done),
        .color_out  (color_out),
        .out_x      (out_x),
        .out_y      (out_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_primed(input string tag);
        chk({tag, "_done"},  32'(pixel_done), 32'd1);
        chk({tag, "_color"}, 32'(color_out),  32'h000000);
        chk({tag, "_x"},     32'(out_x),      32'd0);
        chk({tag, "_y"},     32'(out_y),      32'd0);
    endtask

    // Dispatch one pixel; optionally pulse a bogus start while busy (pulse_at >= 0).
    task automatic run_pixel(input string tag, input logic [10:0] x, input logic [9:0] y,
                             input logic [31:0] t, input int pulse_at,
                             input int exp_lat, input logic [23:0] exp_col);
        int n;
        @(negedge clk_in);
        curr_x = x; curr_y = y; timer = t; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        n = 0;
        chk({tag, "_drop"}, 32'(pixel_done), 32'd0);
        while (!pixel_done && n < 200) begin
            if (n == pulse_at) begin
                start_in = 1'b1; curr_x = 11'd5; curr_y = 10'd7; timer = 32'hFF;
            end
            @(negedge clk_in);
            n++;
            start_in = 1'b0; curr_x = x; curr_y = y; timer = t;
        end
        chk({tag, "_lat"},   32'(n),         32'(exp_lat));
        chk({tag, "_color"}, 32'(color_out), 32'(exp_col));
        chk({tag, "_x"},     32'(out_x),     32'(x));
        chk({tag, "_y"},     32'(out_y),     32'(y));
        repeat (3) @(negedge clk_in);
        chk({tag, "_hold"},     32'(pixel_done), 32'd1);
        chk({tag, "_holdcol"},  32'(color_out),  32'(exp_col));
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; curr_x = '0; curr_y = '0; timer = '0;

        // T1 reset priming and hold
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_primed("t1");
        repeat (10) @(negedge clk_in);
        check_primed("t1_held");

        // T2 centre pixel never escapes
        run_pixel("t2", 11'd640, 10'd360, 32'd0, -1, 67, 24'h000000);
        // T3 c_re = -2.5 escapes at iter 1
        run_pixel("t3", 11'd0, 10'd360, 32'd0, -1, 5, 24'h0102FE);
        // T4 palette rotation, only timer[7:0] counts
        run_pixel("t4", 11'd0, 10'd360, 32'd300, -1, 5, 24'h2D5AD2);
        // Corner pixel escapes at iter 1 with timer 5 -> k = 6
        run_pixel("corner", 11'd1279, 10'd0, 32'd5, -1, 5, 24'h060CF9);
        // c = 1.40625i escapes at iter 2
        run_pixel("imag", 11'd640, 10'd0, 32'd0, -1, 7, 24'h0204FD);
        // Inside-set black regardless of timer
        run_pixel("inside_t", 11'd640, 10'd360, 32'hABCD, -1, 67, 24'h000000);
        // T5 start while busy is ignored; following start is accepted (drop check)
        run_pixel("t5", 11'd640, 10'd360, 32'd0, 10, 67, 24'h000000);
        run_pixel("t5_next", 11'd0, 10'd360, 32'd0, -1, 5, 24'h0102FE);

        // T6 reset during MUL of the centre pixel
        @(negedge clk_in);
        curr_x = 11'd640; curr_y = 10'd360; timer = 32'd0; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_primed("t6");
        repeat (80) @(negedge clk_in);
        check_primed("t6_nostale");

        run_pixel("t6_after", 11'd640, 10'd0, 32'd0, -1, 7, 24'h0204FD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
